contrast_brightness_pipe: RTL and testbench
===========================================

// Module: contrast_brightness_pipe
// PURPOSE
//  Parametrised per-channel contrast/brightness stage for the video pixel path.
//  Computes out = clamp((in*gain) >> GAIN_FRAC + offset) on NUM_CH packed channels.
//  Has a valid/ready stream handshake and is fully pipelined (2 stages).
//  Gain/offset are loaded at run time and take effect only at a frame boundary (sof).
// PARAMETERS
//  CH_W      8  bits per colour channel
//  NUM_CH    3  channels packed in in_data/out_data; channel 0 = LSBs
//  GAIN_W    8  unsigned gain width
//  GAIN_FRAC 2  fractional gain bits; gain value 1<<GAIN_FRAC = unity
//  OFF_W     9  signed two's-complement offset width
// PORTS
//  clk         in   1               rising-edge clock
//  reset_n     in   1               asynchronous, active-low reset
//  in_valid    in   1               input beat valid
//  in_ready    out  1               stage can accept a beat
//  in_sof      in   1               beat is first pixel of frame
//  in_data     in   NUM_CH*CH_W     input pixel
//  out_valid   out  1               output beat valid
//  out_ready   in   1               downstream accepts
//  out_sof     out  1               sof delayed with its pixel
//  out_data    out  NUM_CH*CH_W     adjusted pixel
//  cfg_load    in   1               capture cfg_gain/cfg_offset into pending regs
//  cfg_gain    in   GAIN_W          new gain
//  cfg_offset  in   OFF_W           new signed offset
//  cfg_pending out  1               pending config not yet applied
// BEHAVIOUR
//  - Reset (async, reset_n=0): out_valid=0, out_sof=0, out_data=0, cfg_pending=0,
//    active gain=1<<GAIN_FRAC, active offset=0, all pipeline valids=0.
//  - Advance enable en = !out_valid || out_ready; in_ready = en (combinational).
//    Beat accepted when in_valid && in_ready. When en=0 every stage holds.
//  - Stage 1: register per-channel product in*gain (CH_W+GAIN_W bits, unsigned),
//    sof, valid, and the offset in force for that beat.
//  - Stage 2: shift product right GAIN_FRAC (truncate), sign-extend and add offset in
//    CH_W+GAIN_W+1-bit signed arithmetic; clamp <0 to 0, >2^CH_W-1 to 2^CH_W-1.
//  - Latency: 2 cycles accept->out_valid with out_ready=1; throughput 1 beat/cycle.
//  - Bubbles (in_valid=0 while en=1) propagate as valid=0; data regs may update.
//  - Config: cfg_load=1 writes pending regs, sets cfg_pending=1; a later load
//    overwrites pending (last write wins).
//  - Apply: on an accepted beat with in_sof=1 and cfg_pending=1 (set before this cycle),
//    pending->active and that sof beat already uses the new values; cfg_pending clears.
//  - Same-cycle cfg_load and accepted sof: sof beat uses prior pending (if set) else
//    active; the new load becomes pending, cfg_pending=1 after the cycle.
//  - Beats in flight keep the gain/offset they were accepted with (captured in stage 1).
//  - out_valid/out_data/out_sof stable while out_valid && !out_ready.
//  - reset_n low mid-frame: in-flight beats dropped, config returns to unity/0.
// CONFIGURATION
//  CB_ROUND_EN defined: add 1<<(GAIN_FRAC-1) to the product before the shift
//    (round half up; omitted when GAIN_FRAC=0). Not defined: truncation.
//  Latency/handshake identical either way.
// TESTING
//  1 reset, unity cfg: in_data=0x102030 -> out_data=0x102030 two cycles later, sof kept.
//  2 load gain=8 (2.0), offset=+32, then sof beat 0x40_90_00 -> 0xA0_FF_20 (clamp high);
//    non-sof beats before it still unity.
//  3 offset=-64 (9'h1C0), gain=4: 0x20_50_FF -> 0x00_10_BF (clamp low).
//  4 out_ready=0 for 5 cycles with stream running -> in_ready=0, no beat lost/duplicated,
//    output held; 100-beat random stream vs reference model, random out_ready.
//  5 cfg_load same cycle as sof: sof uses old pending; cfg_pending=1 until next sof.
//  6 CB_ROUND_EN, gain=5 (1.25), in=0x03 -> 0x04 rounded (0x03 without macro).

Source files
------------

// File: rtl/contrast_brightness_pipe.sv
// Two-stage per-channel contrast/brightness adjust with valid/ready handshake.
// Optional build macro CB_ROUND_EN selects round-half-up instead of truncation.
`timescale 1ns/1ps
module contrast_brightness_pipe #(
   parameter int CH_W      = 8,
   parameter int NUM_CH    = 3,
   parameter int GAIN_W    = 8,
   parameter int GAIN_FRAC = 2,
   parameter int OFF_W     = 9
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sof,
   input  logic [NUM_CH*CH_W-1:0]   in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_sof,
   output logic [NUM_CH*CH_W-1:0]   out_data,
   input  logic                     cfg_load,
   input  logic [GAIN_W-1:0]        cfg_gain,
   input  logic [OFF_W-1:0]         cfg_offset,
   output logic                     cfg_pending
);

   localparam int PROD_W = CH_W + GAIN_W;
   localparam int SUM_W  = PROD_W + 1;
   localparam int DATA_W = NUM_CH * CH_W;

`ifdef CB_ROUND_EN
   localparam logic [SUM_W-1:0] ROUND_ADD = SUM_W'((1 << GAIN_FRAC) >> 1);
`else
   localparam logic [SUM_W-1:0] ROUND_ADD = '0;
`endif
   localparam logic [GAIN_W-1:0] UNITY_GAIN = GAIN_W'(1 << GAIN_FRAC);
   localparam logic [SUM_W-1:0]  CH_MAX     = SUM_W'((1 << CH_W) - 1);

   logic                en;
   logic                accept;
   logic                apply;
   logic [GAIN_W-1:0]   act_gain;
   logic [GAIN_W-1:0]   pend_gain;
   logic [GAIN_W-1:0]   beat_gain;
   logic [OFF_W-1:0]    act_off;
   logic [OFF_W-1:0]    pend_off;
   logic [OFF_W-1:0]    beat_off;
   logic [PROD_W-1:0]   prod [NUM_CH];
   logic                s1_valid;
   logic                s1_sof;
   logic [OFF_W-1:0]    s1_off;
   logic [PROD_W-1:0]   s1_prod [NUM_CH];
   logic [DATA_W-1:0]   adj_data;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign accept   = in_valid && en;
   assign apply    = accept && in_sof && cfg_pending;

   // An applying sof beat already sees the pending values it is promoting.
   assign beat_gain = apply ? pend_gain : act_gain;
   assign beat_off  = apply ? pend_off  : act_off;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         act_gain    <= UNITY_GAIN;
         act_off     <= '0;
         pend_gain   <= '0;
         pend_off    <= '0;
         cfg_pending <= 1'b0;
      end else begin
         if (cfg_load) begin
            pend_gain <= cfg_gain;
            pend_off  <= cfg_offset;
         end
         if (apply) begin
            act_gain <= pend_gain;
            act_off  <= pend_off;
         end
         if (cfg_load) begin
            cfg_pending <= 1'b1;
         end else if (apply) begin
            cfg_pending <= 1'b0;
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         prod[c] = PROD_W'(in_data[c*CH_W +: CH_W]) * PROD_W'(beat_gain);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_sof   <= 1'b0;
         s1_off   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            s1_prod[c] <= '0;
         end
      end else if (en) begin
         s1_valid <= accept;
         s1_sof   <= in_sof;
         s1_off   <= beat_off;
         for (int c = 0; c < NUM_CH; c++) begin
            s1_prod[c] <= prod[c];
         end
      end
   end

   // Shifted product is never negative, so only the offset can push the sum below zero.
   always_comb begin
      logic [SUM_W-1:0]        rounded;
      logic [SUM_W-1:0]        shifted;
      logic signed [SUM_W-1:0] total;
      adj_data = '0;
      rounded  = '0;
      shifted  = '0;
      total    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         rounded = {1'b0, s1_prod[c]} + ROUND_ADD;
         shifted = rounded >> GAIN_FRAC;
         total   = $signed(shifted) + $signed({{(SUM_W-OFF_W){s1_off[OFF_W-1]}}, s1_off});
         if (total[SUM_W-1]) begin
            adj_data[c*CH_W +: CH_W] = '0;
         end else if ($unsigned(total) > CH_MAX) begin
            adj_data[c*CH_W +: CH_W] = '1;
         end else begin
            adj_data[c*CH_W +: CH_W] = total[CH_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_data  <= '0;
      end else if (en) begin
         out_valid <= s1_valid;
         out_sof   <= s1_valid && s1_sof;
         out_data  <= adj_data;
      end
   end

endmodule

// File: tb/tb_contrast_brightness_pipe.sv
// Scoreboard bench for contrast_brightness_pipe: directed vectors plus a modelled random stream.
// Honours CB_ROUND_EN the same way the design does.
`timescale 1ns/1ps
module tb_contrast_brightness_pipe;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sof;
   logic [23:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_sof;
   logic [23:0] out_data;
   logic        cfg_load;
   logic [7:0]  cfg_gain;
   logic [8:0]  cfg_offset;
   logic        cfg_pending;

   int checks = 0;
   int errors = 0;
   int beat_no = 0;
   logic [24:0] sb [$];

   contrast_brightness_pipe dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sof      (in_sof),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sof     (out_sof),
      .out_data    (out_data),
      .cfg_load    (cfg_load),
      .cfg_gain    (cfg_gain),
      .cfg_offset  (cfg_offset),
      .cfg_pending (cfg_pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [24:0] actual, input logic [24:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference: per channel clamp(((v*g [+half]) >> 2) + off)
   function automatic logic [23:0] model_px(input logic [23:0] d, input int g, input int off);
      logic [23:0] r;
      r = '0;
      for (int c = 0; c < 3; c++) begin
         int p;
         int v;
         p = int'(d[c*8 +: 8]) * g;
`ifdef CB_ROUND_EN
         p = p + 2;
`endif
         v = (p / 4) + off;
         if (v < 0) v = 0;
         if (v > 255) v = 255;
         r[c*8 +: 8] = 8'(v);
      end
      return r;
   endfunction

   // Presents one beat (optionally with a cfg_load) and records its expected output on acceptance.
   task automatic apply_stimulus(input logic sof, input logic [23:0] data, input logic [23:0] expected,
                                 input logic ld, input logic [7:0] g, input logic [8:0] o);
      bit accepted;
      accepted   = 0;
      in_valid   = 1'b1;
      in_sof     = sof;
      in_data    = data;
      cfg_load   = ld;
      cfg_gain   = g;
      cfg_offset = o;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back({sof, expected});
            accepted = 1;
            break;
         end
      end
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: got in_ready=0 for 200 cycles, want 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      cfg_load = 1'b0;
   endtask

   task automatic load_cfg(input logic [7:0] g, input logic [8:0] o);
      cfg_load   = 1'b1;
      cfg_gain   = g;
      cfg_offset = o;
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
   endtask

   task automatic wait_drain();
      bit drained;
      drained = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            drained = 1;
            break;
         end
      end
      checks++;
      if (!drained) begin
         errors++;
         $display("[TB] FAIL drain: got %0d beats outstanding, want 0", sb.size());
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks output stability while stalled.
   logic        was_stall = 1'b0;
   logic [24:0] held      = '0;
   always @(negedge clk) begin
      if (!reset_n) begin
         was_stall = 1'b0;
      end else begin
         if (was_stall) begin
            check_output("hold_valid", 25'(out_valid), 25'(1));
            check_output("hold_data", {out_sof, out_data}, held);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_beat: got 0x%0h, want no beat", out_data);
            end else begin
               logic [24:0] exp_beat;
               exp_beat = sb.pop_front();
               check_output($sformatf("beat%0d", beat_no), {out_sof, out_data}, exp_beat);
               beat_no++;
            end
         end
         was_stall = out_valid && !out_ready;
         held      = {out_sof, out_data};
      end
   end

   initial begin
      bit done;
      reset_n    = 1'b0;
      in_valid   = 1'b0;
      in_sof     = 1'b0;
      in_data    = '0;
      out_ready  = 1'b1;
      cfg_load   = 1'b0;
      cfg_gain   = '0;
      cfg_offset = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset_out_valid", 25'(out_valid), 25'(0));
      check_output("reset_out_data", 25'(out_data), 25'(0));
      check_output("reset_cfg_pending", 25'(cfg_pending), 25'(0));
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      $display("[TB] unity passthrough and latency");
      apply_stimulus(1'b1, 24'h102030, 24'h102030, 1'b0, 8'd0, 9'd0);
      @(negedge clk);
      check_output("latency_early", 25'(out_valid), 25'(0));
      @(negedge clk);
      check_output("latency_valid", 25'(out_valid), 25'(1));
      wait_drain();

      $display("[TB] gain 2.0 offset +32 applied at sof");
      @(posedge clk);
      #1;
      load_cfg(8'd8, 9'd32);
      check_output("pending_after_load", 25'(cfg_pending), 25'(1));
      apply_stimulus(1'b0, 24'h112233, 24'h112233, 1'b0, 8'd0, 9'd0);
      apply_stimulus(1'b1, 24'h409000, 24'hA0FF20, 1'b0, 8'd0, 9'd0);
      check_output("pending_after_apply", 25'(cfg_pending), 25'(0));
      apply_stimulus(1'b0, 24'h101010, 24'h404040, 1'b0, 8'd0, 9'd0);
      wait_drain();

      $display("[TB] gain 1.0 offset -64 clamp low");
      load_cfg(8'd4, 9'h1C0);
      apply_stimulus(1'b1, 24'h2050FF, 24'h0010BF, 1'b0, 8'd0, 9'd0);
      wait_drain();

      $display("[TB] downstream stall");
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      fork
         begin
            apply_stimulus(1'b0, 24'h808080, 24'h404040, 1'b0, 8'd0, 9'd0);
            apply_stimulus(1'b0, 24'h909090, 24'h505050, 1'b0, 8'd0, 9'd0);
            apply_stimulus(1'b0, 24'hA0A0A0, 24'h606060, 1'b0, 8'd0, 9'd0);
            apply_stimulus(1'b0, 24'hB0B0B0, 24'h707070, 1'b0, 8'd0, 9'd0);
            apply_stimulus(1'b0, 24'hC0C0C0, 24'h808080, 1'b0, 8'd0, 9'd0);
            apply_stimulus(1'b0, 24'hD0D0D0, 24'h909090, 1'b0, 8'd0, 9'd0);
         end
         begin
            repeat (5) @(posedge clk);
            @(negedge clk);
            check_output("stall_in_ready", 25'(in_ready), 25'(0));
            check_output("stall_out_valid", 25'(out_valid), 25'(1));
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain();

      $display("[TB] random stream gain 1.25 offset +3");
      load_cfg(8'd5, 9'd3);
      done = 0;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               logic [23:0] d;
               d = 24'($urandom);
               apply_stimulus(i == 0, d, model_px(d, 5, 3), 1'b0, 8'd0, 9'd0);
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      wait_drain();

      $display("[TB] load coinciding with sof");
      @(posedge clk);
      #1;
      load_cfg(8'd4, 9'd0);
      apply_stimulus(1'b1, 24'h0A1B2C, 24'h0A1B2C, 1'b1, 8'd8, 9'd0);
      check_output("pending_same_cycle", 25'(cfg_pending), 25'(1));
      apply_stimulus(1'b0, 24'h050505, 24'h050505, 1'b0, 8'd0, 9'd0);
      apply_stimulus(1'b1, 24'h101010, 24'h202020, 1'b0, 8'd0, 9'd0);
      check_output("pending_cleared", 25'(cfg_pending), 25'(0));
      wait_drain();

      $display("[TB] rounding");
      load_cfg(8'd5, 9'd0);
`ifdef CB_ROUND_EN
      apply_stimulus(1'b1, 24'h000003, 24'h000004, 1'b0, 8'd0, 9'd0);
`else
      apply_stimulus(1'b1, 24'h000003, 24'h000003, 1'b0, 8'd0, 9'd0);
`endif
      wait_drain();

      $display("[TB] reset mid-frame");
      load_cfg(8'd8, 9'd32);
      out_ready = 1'b0;
      apply_stimulus(1'b0, 24'h111111, 24'h000000, 1'b0, 8'd0, 9'd0);
      reset_n = 1'b0;
      sb.delete();
      @(negedge clk);
      check_output("midreset_out_valid", 25'(out_valid), 25'(0));
      check_output("midreset_pending", 25'(cfg_pending), 25'(0));
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      apply_stimulus(1'b1, 24'h102030, 24'h102030, 1'b0, 8'd0, 9'd0);
      check_output("postreset_pending", 25'(cfg_pending), 25'(0));
      wait_drain();

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
